// File: rtl/chu_io_blink_core.sv
// FPro MMIO slot: N_LED hardware blinkers, each with its own ms half-period.
// Define BLINK_READBACK_EN to read the period/en registers back over rd_data.
module chu_io_blink_core #(
    parameter int N_LED      = 4,
    parameter int CLK_PER_MS = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic [N_LED-1:0] led
);

    localparam int PSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(CLK_PER_MS - 1);
    localparam logic [4:0] EN_ADDR = 5'h10;

    logic [PSW-1:0]   ps_cnt;
    logic             tick;
    logic             wr_en;
    logic [N_LED-1:0] per_wr;
    logic [N_LED-1:0] en;
    logic [15:0]      period [N_LED];
    logic             unused_in;

    assign wr_en     = cs && write;
    assign tick      = (ps_cnt == PS_LAST);
    assign unused_in = &{1'b0, read, wr_data[31:16]};

    always_comb begin
        per_wr = '0;
        for (int i = 0; i < N_LED; i++)
            per_wr[i] = wr_en && (addr == 5'(i));
    end

    // Free-running 1 ms prescaler, untouched by register traffic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ps_cnt <= '0;
        else if (tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en <= '0;
            for (int i = 0; i < N_LED; i++)
                period[i] <= '0;
        end else begin
            for (int i = 0; i < N_LED; i++)
                if (per_wr[i])
                    period[i] <= wr_data[15:0];
            if (wr_en && addr == EN_ADDR)
                en <= wr_data[N_LED-1:0];
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_ch
        logic [15:0] ms_cnt;
        logic        blink;
        logic        led_q;

        // A period write clears the count and beats a same-cycle tick
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ms_cnt <= '0;
                blink  <= 1'b0;
                led_q  <= 1'b0;
            end else begin
                if (!en[g]) begin
                    ms_cnt <= '0;
                    blink  <= 1'b0;
                end else if (per_wr[g] || period[g] == 16'd0) begin
                    ms_cnt <= '0;
                end else if (tick) begin
                    if (ms_cnt == period[g] - 16'd1) begin
                        ms_cnt <= '0;
                        blink  <= ~blink;
                    end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                    end
                end
                led_q <= en[g] && (period[g] == 16'd0 || blink);
            end
        end

        assign led[g] = led_q;
    end

`ifdef BLINK_READBACK_EN
    always_comb begin
        rd_data = '0;
        if (cs && read) begin
            for (int i = 0; i < N_LED; i++)
                if (addr == 5'(i))
                    rd_data[15:0] = period[i];
            if (addr == EN_ADDR)
                rd_data[N_LED-1:0] = en;
        end
    end
`else
    assign rd_data = '0;
`endif

endmodule
